// File: rtl/demux16_dist.sv
// Registered 1-to-16 distributor: single-channel writes or a sequenced
// broadcast of one captured word into all 16 channels, with per-channel ack.
module demux16_dist #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [3:0]          select,
    input  logic                bcast,
    output logic [16*WIDTH-1:0] out_data,
    output logic [15:0]         out_valid,
    input  logic [15:0]         out_ack,
    output logic                busy,
    output logic                bcast_done
);

    typedef enum logic {
        IDLE,
        BCAST
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] wr_data;
    logic [15:0]      wr_en;
    logic             done_nxt;
    logic             free_sel;
    logic             free_cnt;
    logic             accept;

    // A channel can take a word if empty or being drained this same cycle
    assign free_sel = ~out_valid[select] | out_ack[select];
    assign free_cnt = ~out_valid[cnt] | out_ack[cnt];
    assign in_ready = (state == IDLE) & (bcast | free_sel);
    assign accept   = in_valid & in_ready;
    assign busy     = (state == BCAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word;
        wr_en     = '0;
        wr_data   = in_data;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bcast) begin
                        word_nxt  = in_data;
                        cnt_nxt   = 4'd0;
                        state_nxt = BCAST;
                    end else begin
                        wr_en[select] = 1'b1;
                    end
                end
            end
            BCAST: begin
                wr_data = word;
                if (free_cnt) begin
                    wr_en[cnt] = 1'b1;
                    if (cnt == 4'hF) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            word       <= '0;
            bcast_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            word       <= word_nxt;
            bcast_done <= done_nxt;
        end
    end

    // Write beats ack, so a same-cycle ack+write leaves the channel full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (wr_en[k]) begin
                    out_data[k*WIDTH +: WIDTH] <= wr_data;
                    out_valid[k]               <= 1'b1;
                end else if (out_ack[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux16_dist.sv
// Scoreboard bench for demux16_dist: expected channel writes are queued at
// stimulus time and compared once the DUT has committed them.
module tb_demux16_dist;

    localparam int WIDTH = 16;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic [3:0]          select;
    logic                bcast;
    logic [16*WIDTH-1:0] out_data;
    logic [15:0]         out_valid;
    logic [15:0]         out_ack;
    logic                busy;
    logic                bcast_done;

    typedef struct {
        logic [3:0]       ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;
    int   busy_cycles;
    int   done_cnt;
    logic ready_low;

    demux16_dist #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .select     (select),
        .bcast      (bcast),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .busy       (busy),
        .bcast_done (bcast_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] ch, input logic [WIDTH-1:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, out_data[int'(e.ch)*WIDTH +: WIDTH], e.data);
            check({tag, "_vbit"}, out_valid[e.ch], 1'b1);
        end
    endtask

    task automatic single(input logic [3:0] ch, input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        bcast    = 1'b0;
        select   = ch;
        in_data  = d;
        #1;
        check("single_ready", in_ready, 1'b1);
        push_exp(ch, d);
        step();
        in_valid = 1'b0;
        pop_check("single");
    endtask

    task automatic start_bcast(input logic [WIDTH-1:0] d, input bit track);
        in_valid = 1'b1;
        bcast    = 1'b1;
        in_data  = d;
        #1;
        check("bcast_ready", in_ready, 1'b1);
        if (track)
            for (int k = 0; k < 16; k++) push_exp(4'(k), d);
        step();
        in_valid = 1'b0;
        bcast    = 1'b0;
    endtask

    task automatic drain_all();
        out_ack = 16'hFFFF;
        step();
        out_ack = 16'h0;
        check("drain", out_valid, 16'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        select   = '0;
        bcast    = 1'b0;
        out_ack  = '0;
        step();
        step();
        check("rst_valid", out_valid, 16'h0);
        check("rst_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", bcast_done, 1'b0);
        rst_n = 1'b1;
        step();

        // single write and ack
        single(4'h5, 16'h00A5);
        check("single_vec", out_valid, 16'h0020);
        out_ack[5] = 1'b1;
        step();
        out_ack = '0;
        check("ack_clear", out_valid, 16'h0);
        check("ack_keep", out_data[5*WIDTH +: WIDTH], 16'h00A5);

        // back-pressure, then same-cycle ack+write
        single(4'h3, 16'h1111);
        in_valid = 1'b1;
        select   = 4'h3;
        in_data  = 16'h2222;
        #1;
        check("bp_ready", in_ready, 1'b0);
        step();
        check("bp_hold", out_data[3*WIDTH +: WIDTH], 16'h1111);
        out_ack[3] = 1'b1;
        #1;
        check("bp_ack_ready", in_ready, 1'b1);
        push_exp(4'h3, 16'h2222);
        step();
        in_valid = 1'b0;
        out_ack  = '0;
        pop_check("ackwr");
        check("ackwr_vec", out_valid, 16'h0008);
        drain_all();

        // broadcast without stalls
        start_bcast(16'hBEEF, 1'b1);
        busy_cycles = busy ? 1 : 0;
        done_cnt    = 0;
        ready_low   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy && in_ready) ready_low = 1'b0;
            step();
            if (busy) busy_cycles++;
            if (bcast_done) done_cnt++;
        end
        check("bc_busy_cycles", busy_cycles, 16);
        check("bc_done_pulses", done_cnt, 1);
        check("bc_ready_low", ready_low, 1'b1);
        check("bc_vec", out_valid, 16'hFFFF);
        pop_check("bc");
        drain_all();

        // broadcast stalled on ch8 for five cycles
        single(4'h8, 16'h0808);
        start_bcast(16'hC0DE, 1'b1);
        busy_cycles = busy ? 1 : 0;
        done_cnt    = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 13) out_ack[8] = 1'b1;
            step();
            out_ack = '0;
            if (busy) busy_cycles++;
            if (bcast_done) done_cnt++;
            if (i == 12) begin
                check("stall_vec", out_valid, 16'h01FF);
                check("stall_busy", busy, 1'b1);
                check("stall_ch8", out_data[8*WIDTH +: WIDTH], 16'h0808);
            end
        end
        check("stall_cycles", busy_cycles, 21);
        check("stall_done", done_cnt, 1);
        check("stall_vecf", out_valid, 16'hFFFF);
        pop_check("stall");
        drain_all();

        // asynchronous reset in the middle of a broadcast
        start_bcast(16'h6666, 1'b0);
        for (int i = 0; i < 6; i++) step();
        check("mid_vec", out_valid, 16'h003F);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 16'h0);
        check("arst_data", out_data, '0);
        check("arst_busy", busy, 1'b0);
        #1;
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bcast_done) done_cnt++;
        end
        check("arst_nodone", done_cnt, 0);
        check("arst_idle", busy, 1'b0);
        single(4'h9, 16'h9999);
        check("post_vec", out_valid, 16'h0200);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
